// File: rtl/tri_pkg.sv
// tri_pkg: request and return type encodings shared by the transducer and
// the L1.5 side of the request/response protocol.
//   l15_reqtypes_t  - request kinds driven by the transducer master
//   l15_rtrntypes_t - return kinds driven by the L1.5 responder
package tri_pkg;

  typedef enum logic [4:0] {
    LOAD_RQ     = 5'b00000,
    STORE_RQ    = 5'b00001,
    PREFETCH_RQ = 5'b00101,
    ATOMIC_RQ   = 5'b00110,
    IMISS_RQ    = 5'b10000
  } l15_reqtypes_t;

  typedef enum logic [3:0] {
    LOAD_RET   = 4'b0000,
    IFILL_RET  = 4'b0001,
    EVICT_REQ  = 4'b0011,
    ST_ACK     = 4'b0100,
    ATOMIC_RET = 4'b1110
  } l15_rtrntypes_t;

endpackage

// File: rtl/tri_l15_resp_model.sv
// tri_l15_resp_model: responder end of the transducer/L1.5 request-response
// protocol. One request at a time is accepted, serviced against a small
// internal line memory and answered with a held ready/valid response.
//
// Parameters
//   MEM_LINES - number of 128-bit lines in the backing store (power of two, >=2)
//   LATENCY   - idle cycles between acceptance and first resp_val (0..15)
//
// Ports
//   clk, rst        - clock, synchronous active-high reset
//   req_valid       - request valid (only looked at in IDLE)
//   req_type        - LOAD_RQ / STORE_RQ / ATOMIC_RQ (others get a plain ST_ACK)
//   req_amo_op      - atomic opcode: 0 swap, 1 add, 2 and, 3 or, 4 xor
//   req_size        - log2 of access bytes, >=4 means the whole line
//   req_addr        - byte address; line index wraps modulo MEM_LINES
//   req_data        - store/AMO operand, lanes aligned to req_addr[3:0]
//   req_ack         - one-cycle pulse the cycle after a request is taken
//   resp_val        - response valid, held until resp_ack
//   resp_type       - LOAD_RET / ST_ACK / ATOMIC_RET / EVICT_REQ
//   resp_atomic     - response belongs to an atomic
//   resp_data       - line (load), old line (atomic), zero otherwise
//   resp_inv_addr   - invalidation line address [15:4]
//   resp_inv_valid  - response is an invalidation
//   resp_ack        - master accepts the response
//
// Optional feature (macro TRI_RESP_MODEL_INV_EN):
//   inv_req, inv_addr - post an invalidation; it is issued as an EVICT_REQ
//   beat from IDLE whenever no request competes for that cycle. Without the
//   macro the invalidation outputs are tied to zero.
module tri_l15_resp_model #(
  parameter int MEM_LINES = 64,
  parameter int LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  tri_pkg::l15_reqtypes_t  req_type,
  input  logic [3:0]              req_amo_op,
  input  logic [2:0]              req_size,
  input  logic [39:0]             req_addr,
  input  logic [127:0]            req_data,
  output logic                    req_ack,
  output logic                    resp_val,
  output tri_pkg::l15_rtrntypes_t resp_type,
  output logic                    resp_atomic,
  output logic [127:0]            resp_data,
  output logic [11:0]             resp_inv_addr,
  output logic                    resp_inv_valid,
`ifdef TRI_RESP_MODEL_INV_EN
  input  logic                    inv_req,
  input  logic [11:0]             inv_addr,
`endif
  input  logic                    resp_ack
);

  import tri_pkg::*;

  localparam int         IDX_W    = $clog2(MEM_LINES);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Access width in bytes: 1,2,4,8 or the whole 16-byte line.
  function automatic logic [4:0] size_bytes(input logic [2:0] size);
    return (size >= 3'd4) ? 5'd16 : (5'd1 << size);
  endfunction

  // Lane offset aligned down to the access size so lanes never cross the line.
  function automatic logic [3:0] align_ofs(input logic [2:0] size, input logic [3:0] ofs);
    logic [4:0] n;
    n = size_bytes(size);
    return ofs & ~(n[3:0] - 4'd1);
  endfunction

  function automatic logic [127:0] lane_bits(input logic [2:0] size, input logic [3:0] ofs);
    logic [127:0] m;
    int           lo;
    int           hi;
    lo = int'(align_ofs(size, ofs));
    hi = lo + int'(size_bytes(size));
    m  = '0;
    for (int i = 0; i < 16; i++) begin
      if (i >= lo && i < hi) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Atomic result for the addressed lanes. The add is done on the line
  // shifted down to lane 0 so the carry chain starts at the access's LSB;
  // anything carried past the access width lands in unmasked lanes.
  function automatic logic [127:0] amo_value(input logic [3:0]   op,
                                              input logic [127:0] old_line,
                                              input logic [127:0] opd,
                                              input logic [3:0]   ofs);
    logic [6:0]   sh;
    logic [127:0] sum;
    logic [127:0] v;
    sh  = {ofs, 3'b000};
    sum = ((old_line >> sh) + (opd >> sh)) << sh;
    case (op)
      4'd0:    v = opd;
      4'd1:    v = sum;
      4'd2:    v = old_line & opd;
      4'd3:    v = old_line | opd;
      4'd4:    v = old_line ^ opd;
      default: v = old_line;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old_line,
                                          input logic [127:0] new_val,
                                          input logic [127:0] bits);
    return (old_line & ~bits) | (new_val & bits);
  endfunction

  state_t         state;
  logic [3:0]     cnt;
  logic [127:0]   mem [MEM_LINES];

  logic [IDX_W-1:0] cur_idx;
  logic [127:0]     cur_line;
  logic [3:0]       cur_ofs;
  logic [127:0]     cur_bits;
  logic [127:0]     upd_line;
  logic             cur_we;
  l15_rtrntypes_t   cur_rtype;
  logic             cur_ratomic;
  logic [127:0]     cur_rdata;

  l15_rtrntypes_t   rtype_p0;
  logic             ratomic_p0;
  logic [127:0]     rdata_p0;

  logic unused_addr;
  assign unused_addr = ^req_addr[39:4+IDX_W];

  always_comb begin
    cur_idx     = req_addr[4 +: IDX_W];
    cur_line    = mem[cur_idx];
    cur_ofs     = align_ofs(req_size, req_addr[3:0]);
    cur_bits    = lane_bits(req_size, req_addr[3:0]);
    upd_line    = cur_line;
    cur_we      = 1'b0;
    cur_rtype   = ST_ACK;
    cur_ratomic = 1'b0;
    cur_rdata   = '0;
    case (req_type)
      LOAD_RQ: begin
        cur_rtype = LOAD_RET;
        cur_rdata = cur_line;
      end
      STORE_RQ: begin
        upd_line = merge(cur_line, req_data, cur_bits);
        cur_we   = 1'b1;
      end
      ATOMIC_RQ: begin
        cur_rtype   = ATOMIC_RET;
        cur_ratomic = 1'b1;
        cur_rdata   = cur_line;
        upd_line    = merge(cur_line, amo_value(req_amo_op, cur_line, req_data, cur_ofs), cur_bits);
        cur_we      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef TRI_RESP_MODEL_INV_EN
  logic        inv_pend;
  logic [11:0] inv_addr_q;
  logic        inv_done;

  assign inv_done = (state == RESP) && resp_ack && resp_inv_valid;

  // A fresh inv_req takes priority over clearing, so one arriving on the
  // acking cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_pend   <= 1'b0;
      inv_addr_q <= '0;
    end else if (inv_req) begin
      inv_pend   <= 1'b1;
      inv_addr_q <= inv_addr;
    end else if (inv_done) begin
      inv_pend   <= 1'b0;
    end
  end
`else
  assign resp_inv_valid = 1'b0;
  assign resp_inv_addr  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ack     <= 1'b0;
      resp_val    <= 1'b0;
      resp_type   <= LOAD_RET;
      resp_atomic <= 1'b0;
      resp_data   <= '0;
      rtype_p0    <= LOAD_RET;
      ratomic_p0  <= 1'b0;
      rdata_p0    <= '0;
`ifdef TRI_RESP_MODEL_INV_EN
      resp_inv_valid <= 1'b0;
      resp_inv_addr  <= '0;
`endif
      for (int i = 0; i < MEM_LINES; i++) mem[i] <= '0;
    end else begin
      req_ack <= 1'b0;
      case (state)
        // Capture: memory is read-modify-written here, response is latched
        // into the _p0 stage.
        IDLE: begin
          if (req_valid) begin
            if (cur_we) mem[cur_idx] <= upd_line;
            rtype_p0   <= cur_rtype;
            ratomic_p0 <= cur_ratomic;
            rdata_p0   <= cur_rdata;
            req_ack    <= 1'b1;
            cnt        <= CNT_INIT;
            if (LATENCY == 0) begin
              state       <= RESP;
              resp_val    <= 1'b1;
              resp_type   <= cur_rtype;
              resp_atomic <= cur_ratomic;
              resp_data   <= cur_rdata;
            end else begin
              state <= WAIT;
            end
          end
`ifdef TRI_RESP_MODEL_INV_EN
          else if (inv_pend) begin
            state          <= RESP;
            resp_val       <= 1'b1;
            resp_type      <= EVICT_REQ;
            resp_atomic    <= 1'b0;
            resp_data      <= '0;
            resp_inv_valid <= 1'b1;
            resp_inv_addr  <= inv_addr_q;
          end
`endif
        end
        // Latency: count down, then present the captured response.
        WAIT: begin
          if (cnt == 4'd0) begin
            state       <= RESP;
            resp_val    <= 1'b1;
            resp_type   <= rtype_p0;
            resp_atomic <= ratomic_p0;
            resp_data   <= rdata_p0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // Response: hold every field until the master acks.
        RESP: begin
          if (resp_ack) begin
            state       <= IDLE;
            resp_val    <= 1'b0;
            resp_type   <= LOAD_RET;
            resp_atomic <= 1'b0;
            resp_data   <= '0;
`ifdef TRI_RESP_MODEL_INV_EN
            resp_inv_valid <= 1'b0;
            resp_inv_addr  <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_l15_resp_model.sv
// tb_tri_l15_resp_model: table-driven directed vectors, hand-written
// multi-cycle sequences (hold/stability, reset mid-request, invalidation)
// and randomized requests checked against a byte-array reference model.
module tb_tri_l15_resp_model;
  import tri_pkg::*;

  localparam int MEM_LINES = 64;
  localparam int LATENCY   = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  l15_reqtypes_t  req_type;
  logic [3:0]     req_amo_op;
  logic [2:0]     req_size;
  logic [39:0]    req_addr;
  logic [127:0]   req_data;
  logic           req_ack;
  logic           resp_val;
  l15_rtrntypes_t resp_type;
  logic           resp_atomic;
  logic [127:0]   resp_data;
  logic [11:0]    resp_inv_addr;
  logic           resp_inv_valid;
  logic           resp_ack;
`ifdef TRI_RESP_MODEL_INV_EN
  logic           inv_req;
  logic [11:0]    inv_addr;
`endif

  always #5 clk = ~clk;

  tri_l15_resp_model #(.MEM_LINES(MEM_LINES), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type),
    .req_amo_op(req_amo_op), .req_size(req_size), .req_addr(req_addr),
    .req_data(req_data), .req_ack(req_ack), .resp_val(resp_val),
    .resp_type(resp_type), .resp_atomic(resp_atomic), .resp_data(resp_data),
    .resp_inv_addr(resp_inv_addr), .resp_inv_valid(resp_inv_valid),
`ifdef TRI_RESP_MODEL_INV_EN
    .inv_req(inv_req), .inv_addr(inv_addr),
`endif
    .resp_ack(resp_ack)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] model_mem [MEM_LINES];
  l15_reqtypes_t kinds [4] = '{LOAD_RQ, STORE_RQ, ATOMIC_RQ, IMISS_RQ};

  typedef struct {
    l15_reqtypes_t  t;
    logic [3:0]     op;
    logic [2:0]     sz;
    logic [39:0]    a;
    logic [127:0]   d;
    l15_rtrntypes_t et;
    logic           ea;
    logic [127:0]   ed;
    int             hold;
    bit             keep;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MEM_LINES; i++) model_mem[i] = '0;
  endtask

  // Reference: the line is a 16-byte array; lanes o..o+n-1 are updated one
  // byte at a time, the add rippling its carry from the lowest lane upward.
  task automatic model_access(input l15_reqtypes_t t, input logic [3:0] op,
                              input logic [2:0] sz, input logic [39:0] a,
                              input logic [127:0] d, output l15_rtrntypes_t et,
                              output logic ea, output logic [127:0] ed);
    int idx, n, o, carry, s;
    logic [7:0] ob [16];
    logic [7:0] nb [16];
    logic [7:0] db [16];
    idx = int'((a >> 4) % 40'(MEM_LINES));
    n   = (sz >= 3'd4) ? 16 : (1 << sz);
    o   = (int'(a[3:0]) / n) * n;
    for (int i = 0; i < 16; i++) begin
      ob[i] = model_mem[idx][8*i +: 8];
      db[i] = d[8*i +: 8];
      nb[i] = ob[i];
    end
    et = ST_ACK; ea = 1'b0; ed = '0;
    carry = 0;
    case (t)
      LOAD_RQ: begin
        et = LOAD_RET;
        ed = model_mem[idx];
      end
      STORE_RQ: for (int i = o; i < o + n; i++) nb[i] = db[i];
      ATOMIC_RQ: begin
        et = ATOMIC_RET;
        ea = 1'b1;
        ed = model_mem[idx];
        for (int i = o; i < o + n; i++) begin
          case (op)
            4'd0: nb[i] = db[i];
            4'd1: begin
              s     = int'(ob[i]) + int'(db[i]) + carry;
              nb[i] = 8'(s);
              carry = s / 256;
            end
            4'd2: nb[i] = ob[i] & db[i];
            4'd3: nb[i] = ob[i] | db[i];
            4'd4: nb[i] = ob[i] ^ db[i];
            default: nb[i] = ob[i];
          endcase
        end
      end
      default: ;
    endcase
    for (int i = 0; i < 16; i++) model_mem[idx][8*i +: 8] = nb[i];
  endtask

  // Issues one request from IDLE, checks ack timing, latency, stability over
  // 'hold' un-acked cycles and absence of a second ack, then acks it.
  task automatic do_req(input string nm, input l15_reqtypes_t t, input logic [3:0] op,
                        input logic [2:0] sz, input logic [39:0] a, input logic [127:0] d,
                        input int hold, input bit keep,
                        output int got_t, output int got_a, output logic [127:0] got_d);
    int c;
    bit spur, unstable;
    logic [127:0] d0;
    l15_rtrntypes_t t0;
    logic a0;
    spur = 0; unstable = 0;
    req_valid = 1'b1; req_type = t; req_amo_op = op; req_size = sz;
    req_addr = a; req_data = d;
    tick();
    chkn({nm, " req_ack"}, int'(req_ack), 1);
    if (!keep) req_valid = 1'b0;
    c = 1;
    while (!resp_val && c < 40) begin
      tick();
      c++;
      if (req_ack) spur = 1;
    end
    chkn({nm, " latency"}, c, 1 + LATENCY);
    got_t = int'(resp_type); got_a = int'(resp_atomic); got_d = resp_data;
    chkn({nm, " inv_valid"}, int'(resp_inv_valid), 0);
    chkn({nm, " inv_addr"}, int'(resp_inv_addr), 0);
    d0 = resp_data; t0 = resp_type; a0 = resp_atomic;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (req_ack) spur = 1;
      if (!resp_val || resp_data !== d0 || resp_type !== t0 || resp_atomic !== a0) unstable = 1;
    end
    if (hold > 0) chkn({nm, " stable"}, int'(unstable), 0);
    chkn({nm, " single ack"}, int'(spur), 0);
    resp_ack = 1'b1;
    req_valid = 1'b0;
    tick();
    resp_ack = 1'b0;
    chkn({nm, " idle after ack"}, int'(resp_val), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gt, ga;
    logic [127:0] gd;
    l15_rtrntypes_t et;
    logic ea;
    logic [127:0] ed;
    bit seen;

    tbl[0]  = '{LOAD_RQ,   4'd0, 3'd4, 40'h40,  128'h0, LOAD_RET, 1'b0, 128'h0, 0, 1'b0};
    tbl[1]  = '{STORE_RQ,  4'd0, 3'd3, 40'h48,  {64'h1122334455667788, 64'h0}, ST_ACK, 1'b0, 128'h0, 0, 1'b0};
    tbl[2]  = '{LOAD_RQ,   4'd0, 3'd4, 40'h40,  128'h0, LOAD_RET, 1'b0, {64'h1122334455667788, 64'h0}, 5, 1'b1};
    tbl[3]  = '{STORE_RQ,  4'd0, 3'd2, 40'h40,  128'h1, ST_ACK, 1'b0, 128'h0, 0, 1'b0};
    tbl[4]  = '{ATOMIC_RQ, 4'd1, 3'd2, 40'h40,  128'hFFFFFFFF, ATOMIC_RET, 1'b1, {64'h1122334455667788, 64'h1}, 1, 1'b0};
    tbl[5]  = '{LOAD_RQ,   4'd0, 3'd4, 40'h40,  128'h0, LOAD_RET, 1'b0, {64'h1122334455667788, 64'h0}, 0, 1'b0};
    tbl[6]  = '{LOAD_RQ,   4'd0, 3'd4, 40'h440, 128'h0, LOAD_RET, 1'b0, {64'h1122334455667788, 64'h0}, 0, 1'b0};
    tbl[7]  = '{ATOMIC_RQ, 4'd7, 3'd4, 40'h40,  {128{1'b1}}, ATOMIC_RET, 1'b1, {64'h1122334455667788, 64'h0}, 0, 1'b0};
    tbl[8]  = '{STORE_RQ,  4'd0, 3'd0, 40'h44F, {8'hAB, 120'h0}, ST_ACK, 1'b0, 128'h0, 0, 1'b0};
    tbl[9]  = '{LOAD_RQ,   4'd0, 3'd4, 40'h40,  128'h0, LOAD_RET, 1'b0, {64'hAB22334455667788, 64'h0}, 0, 1'b0};
    tbl[10] = '{IMISS_RQ,  4'd0, 3'd4, 40'h40,  {128{1'b1}}, ST_ACK, 1'b0, 128'h0, 2, 1'b1};
    tbl[11] = '{LOAD_RQ,   4'd0, 3'd4, 40'h40,  128'h0, LOAD_RET, 1'b0, {64'hAB22334455667788, 64'h0}, 0, 1'b0};
    tbl[12] = '{ATOMIC_RQ, 4'd4, 3'd1, 40'h4B,  {32'h0, 16'hFFFF, 80'h0}, ATOMIC_RET, 1'b1, {64'hAB22334455667788, 64'h0}, 0, 1'b0};
    tbl[13] = '{LOAD_RQ,   4'd0, 3'd4, 40'h40,  128'h0, LOAD_RET, 1'b0, {64'hAB223344AA997788, 64'h0}, 0, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_type = LOAD_RQ; req_amo_op = '0; req_size = '0;
    req_addr = '0; req_data = '0; resp_ack = 1'b0;
`ifdef TRI_RESP_MODEL_INV_EN
    inv_req = 1'b0; inv_addr = '0;
`endif
    clear_model();
    tick(); tick();
    rst = 1'b0;
    chkn("reset req_ack", int'(req_ack), 0);
    chkn("reset resp_val", int'(resp_val), 0);
    chkn("reset resp_type", int'(resp_type), 0);
    chkn("reset resp_atomic", int'(resp_atomic), 0);
    chk("reset resp_data", resp_data, 128'h0);
    chkn("reset inv_valid", int'(resp_inv_valid), 0);

    for (int i = 0; i < 14; i++) begin
      model_access(tbl[i].t, tbl[i].op, tbl[i].sz, tbl[i].a, tbl[i].d, et, ea, ed);
      do_req($sformatf("vec%0d", i), tbl[i].t, tbl[i].op, tbl[i].sz, tbl[i].a, tbl[i].d,
             tbl[i].hold, tbl[i].keep, gt, ga, gd);
      chkn($sformatf("vec%0d type", i), gt, int'(tbl[i].et));
      chkn($sformatf("vec%0d atomic", i), ga, int'(tbl[i].ea));
      chk($sformatf("vec%0d data", i), gd, tbl[i].ed);
    end

    // Reset while the request is still counting latency.
    req_valid = 1'b1; req_type = STORE_RQ; req_size = 3'd4; req_addr = 40'h60;
    req_data = {128{1'b1}};
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkn("wait-reset resp_val", int'(resp_val), 0);
    chkn("wait-reset req_ack", int'(req_ack), 0);
    chk("wait-reset resp_data", resp_data, 128'h0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (resp_val) seen = 1;
    end
    chkn("wait-reset no response", int'(seen), 0);
    clear_model();
    do_req("post-reset line4", LOAD_RQ, 4'd0, 3'd4, 40'h40, 128'h0, 0, 1'b0, gt, ga, gd);
    chk("post-reset line4 data", gd, 128'h0);
    do_req("post-reset line6", LOAD_RQ, 4'd0, 3'd4, 40'h60, 128'h0, 0, 1'b0, gt, ga, gd);
    chk("post-reset line6 data", gd, 128'h0);

`ifdef TRI_RESP_MODEL_INV_EN
    // Invalidation posted in the same IDLE cycle as a load: load goes first.
    model_access(LOAD_RQ, 4'd0, 3'd4, 40'h40, 128'h0, et, ea, ed);
    req_valid = 1'b1; req_type = LOAD_RQ; req_size = 3'd4; req_addr = 40'h40;
    inv_req = 1'b1; inv_addr = 12'h123;
    tick();
    req_valid = 1'b0; inv_req = 1'b0;
    chkn("inv load req_ack", int'(req_ack), 1);
    for (int k = 0; k < 20 && !resp_val; k++) tick();
    chkn("inv load type", int'(resp_type), int'(LOAD_RET));
    chkn("inv load inv_valid", int'(resp_inv_valid), 0);
    chk("inv load data", resp_data, ed);
    resp_ack = 1'b1; tick(); resp_ack = 1'b0;
    for (int k = 0; k < 20 && !resp_val; k++) tick();
    chkn("evict val", int'(resp_val), 1);
    chkn("evict type", int'(resp_type), int'(EVICT_REQ));
    chkn("evict inv_valid", int'(resp_inv_valid), 1);
    chkn("evict inv_addr", int'(resp_inv_addr), 12'h123);
    chk("evict data", resp_data, 128'h0);
    chkn("evict atomic", int'(resp_atomic), 0);
    resp_ack = 1'b1; tick(); resp_ack = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (resp_val) seen = 1;
    end
    chkn("evict cleared", int'(seen), 0);
`endif

    for (int i = 0; i < 150; i++) begin
      l15_reqtypes_t t;
      logic [3:0] op;
      logic [2:0] sz;
      logic [39:0] a;
      logic [127:0] d;
      int r;
      r  = int'($urandom_range(0, 9));
      t  = (r < 3) ? kinds[0] : (r < 6) ? kinds[1] : (r < 9) ? kinds[2] : kinds[3];
      op = 4'($urandom_range(0, 7));
      sz = 3'($urandom_range(0, 5));
      a  = {30'($urandom), 6'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      d  = {$urandom, $urandom, $urandom, $urandom};
      model_access(t, op, sz, a, d, et, ea, ed);
      do_req($sformatf("rnd%0d", i), t, op, sz, a, d, int'($urandom_range(0, 2)),
             bit'($urandom_range(0, 1)), gt, ga, gd);
      chkn($sformatf("rnd%0d type", i), gt, int'(et));
      chkn($sformatf("rnd%0d atomic", i), ga, int'(ea));
      chk($sformatf("rnd%0d data", i), gd, ed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
